// File: rtl/alu_acc_ctrl.sv
// Accumulator command sequencer wrapped around an external combinational alu_8bit.
// One command per handshake: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_acc_ctrl #(
  parameter logic [7:0] ACC_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_load,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_c,
  output logic       rsp_z,
  output logic [7:0] acc
);

  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; the sender holds its payload stable until then, and
  // ready never depends combinationally on valid (both flags are state decodes).
  state_t state;
  state_t state_next;

  logic [7:0] acc_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic       load_q;
  logic [7:0] rsp_data_q;
  logic       rsp_c_q;
  logic       rsp_z_q;

  logic       cmd_fire;
  logic       rsp_fire;
  logic [7:0] exec_result;
  logic       exec_carry;
  logic       acc_we;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU-facing operand registers only move on an accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_b_q  <= 8'h00;
      alu_op_q <= OP_PASS;
      load_q   <= 1'b0;
    end else if (cmd_fire) begin
      alu_b_q  <= cmd_data;
      alu_op_q <= cmd_op;
      load_q   <= cmd_load;
    end
  end

  // A load reuses the registered operand B as the value, so cmd_data need
  // not be held past the handshake.
  always_comb begin
    exec_result = alu_y;
    exec_carry  = alu_cout;
    acc_we      = 1'b0;
    if (state == EXEC) begin
      if (load_q) begin
        exec_result = alu_b_q;
        exec_carry  = 1'b0;
        acc_we      = 1'b1;
      end else begin
        acc_we = (alu_op_q != OP_CMP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= ACC_RST;
    end else if (acc_we) begin
      acc_q <= exec_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 8'h00;
      rsp_c_q    <= 1'b0;
      rsp_z_q    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data_q <= exec_result;
      rsp_c_q    <= exec_carry;
      rsp_z_q    <= (exec_result == 8'h00);
    end
  end

  assign acc      = acc_q;
  assign alu_a    = acc_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_c    = rsp_c_q;
  assign rsp_z    = rsp_z_q;

endmodule

// File: doc/alu_acc_ctrl.md
# alu_acc_ctrl

Accumulator-based command sequencer placed directly upstream of the combinational `alu_8bit`, with its result path fed back from it. It accepts one command at a time over a valid/ready handshake and holds the accumulator that drives ALU operand A. It registers operand B and the opcode into the ALU, captures `Y`/`Cout` one cycle later, and writes the result back to the accumulator. Each completed command returns a response carrying the result and the C/Z flags.

## Interface

- `ACC_RST`, default `8'h00`: accumulator value on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  3  ALU opcode, same encoding as `alu_8bit`:
  - 000 RCA add, 001 CLA add, 010 CSA add, 011 sub
  - 100 inc A, 101 dec A, 110 compare, 111 pass A
- `cmd_load`  in  1  when 1, load `cmd_data` into the accumulator; the ALU result is ignored.
- `cmd_data`  in  8  operand B, or the load value.
- `alu_a`  out  8  to ALU `A`; always equals the accumulator.
- `alu_b`  out  8  to ALU `B`; registered.
- `alu_op`  out  3  to ALU `op`; registered.
- `alu_y`  in  8  from ALU `Y`.
- `alu_cout`  in  1  from ALU `Cout`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_data`  out  8  result value.
- `rsp_c`  out  1  carry flag.
- `rsp_z`  out  1  zero flag.
- `acc`  out  8  current accumulator, for observation.

## Operation

FSM states: IDLE, EXEC, RESP.

- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: `alu_b <= cmd_data`, `alu_op <= cmd_op`, latch `cmd_load` internally, go to EXEC.
- **EXEC** (exactly one cycle)
  - ALU inputs are stable and `alu_y`/`alu_cout` are sampled at the end of this cycle.
  - `cmd_load`=1: `acc <= cmd_data`, `rsp_data <= cmd_data`, `rsp_c <= 0`.
  - op 110 (compare): `acc` unchanged, `rsp_data <= alu_y`, `rsp_c <= alu_cout`.
  - All other ops: `acc <= alu_y`, `rsp_data <= alu_y`, `rsp_c <= alu_cout`.
  - All cases: `rsp_z <= (new rsp_data == 8'h00)`. Go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_data`, `rsp_c`, `rsp_z` are held stable until `rsp_valid && rsp_ready`; then return to IDLE.
- Flag semantics: the C flag is `Cout` exactly as the ALU returns it, with no reinterpretation for sub, inc, dec or compare.
- Arithmetic is 8-bit only; wrap-around is whatever the ALU produces.
- Response outputs keep their last values after the handshake until the next EXEC.

Reset (`rst_n`=0, asynchronous):
- State goes to IDLE.
- `acc`/`alu_a` = `ACC_RST`, `alu_b` = 0, `alu_op` = 3'b111, `rsp_valid` = 0, `rsp_data` = 0, `rsp_c` = 0, `rsp_z` = 0.
- `cmd_ready` = 1 after reset is released.

Boundary conditions:
- `cmd_valid` while in EXEC or RESP: ignored (`cmd_ready` = 0); upstream must hold the command.
- `rsp_ready` high before `rsp_valid`: no effect.
- Reset asserted mid-EXEC or mid-RESP: the transaction is dropped, no response is issued, and `acc` returns to `ACC_RST`.
- Changes on `cmd_*` outside an accepted handshake never reach `alu_b`/`alu_op`.

## Timing

- Command accepted at rising edge k:
  - `alu_b`/`alu_op` update at k.
  - `acc` and `rsp_*` update at k+1.
  - `rsp_valid` is high from k+1.
- With `rsp_ready` held at 1, the response completes at edge k+2 and `cmd_ready` is high again after k+2.
- Peak throughput: one command per 3 cycles.
- `cmd_ready` and `rsp_valid` are decoded from state registers only, with no combinational path from inputs.
- The `alu_y` path must settle within one cycle: registered B/op through `alu_8bit` to the accumulator.

## Test plan

- Reset with `ACC_RST`=8'h00 → `acc`=00, `rsp_valid`=0, `cmd_ready`=1, `alu_op`=111.
- Load 8'h3C, then op 000 with data 8'h27 → `rsp_data`=63, `rsp_c`=0, `rsp_z`=0, `acc`=63; `rsp_valid` high 1 cycle after acceptance.
- Load 8'hB5, then op 010 with data 8'h6E → `rsp_data`=23, `rsp_c`=1, `acc`=23.
- Load 8'hFF, then op 100 → `rsp_data`=00, `rsp_z`=1, `acc`=00.
- Load 8'h40, then op 110 with data 8'h20 → `acc` stays 40; `rsp_data`/`rsp_c` equal the ALU outputs.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles with `cmd_valid`=1 → `rsp_*` stable, `cmd_ready`=0, the second command is not accepted until after the handshake.
  - Assert `rst_n`=0 during EXEC → no response, `acc`=`ACC_RST`.
